xfipcs_slip_ctrl: RTL and testbench



---
 rtl/xfipcs_pkg.sv | 21 ++
 rtl/xfipcs_sat_cnt.sv | 26 ++
 rtl/xfipcs_slip_ctrl.sv | 150 +++++++++++++++
 tb/tb_xfipcs_slip_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xfipcs_pkg.sv
// Shared constants and types for the XFI PCS block-alignment (slip) controller.
package xfipcs_pkg;

    localparam int unsigned NUM_POS_DEF = 66;
    localparam int unsigned SETTLE_W    = 4;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        SETTLE   = 2'd1,
        DONE     = 2'd2,
        WAIT_LOW = 2'd3
    } slip_state_e;

    function automatic logic sh_is_valid(input logic [1:0] hdr);
        return (hdr == SH_DATA) || (hdr == SH_CTRL);
    endfunction

endpackage

// File: rtl/xfipcs_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module xfipcs_sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/xfipcs_slip_ctrl.sv
// XFI receive block-alignment controller: tests sync headers and services slip requests.
// Statistics counters are built only when XFIPCS_SLIP_STATS_EN is defined.
module xfipcs_slip_ctrl
    import xfipcs_pkg::*;
#(
    parameter int unsigned NUM_POS    = NUM_POS_DEF,
    parameter int unsigned OFFSET_W   = 7,
    parameter int unsigned SETTLE_BLK = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_in_enable,
    input  logic [1:0]          i_sync_hdr,
    input  logic                i_signal_ok,
    input  logic                i_slip,
    input  logic                i_block_lock,
    output logic                o_sh_valid,
    output logic                o_test_sh_set,
    output logic                o_slip_done_set,
    output logic [OFFSET_W-1:0] o_bit_offset,
    output logic [CNT_W-1:0]    o_slip_cnt,
    output logic [CNT_W-1:0]    o_hunt_wrap_cnt
);

    slip_state_e         r_state, w_state_d;
    logic [SETTLE_W-1:0] r_settle, w_settle_d;
    logic [OFFSET_W-1:0] r_bit_offset, w_bit_offset_d;
    logic                r_sh_valid, w_sh_valid_d;
    logic                r_test_sh_set, w_test_sh_set_d;
    logic                r_slip_done_set, w_slip_done_set_d;
    logic                w_slip_take;
    logic                w_offset_last;

    assign w_offset_last = (r_bit_offset == OFFSET_W'(NUM_POS - 1));

    always_comb begin
        w_state_d         = r_state;
        w_settle_d        = r_settle;
        w_bit_offset_d    = r_bit_offset;
        w_sh_valid_d      = r_sh_valid;
        w_test_sh_set_d   = 1'b0;
        w_slip_done_set_d = 1'b0;
        w_slip_take       = 1'b0;

        // Loss of signal aborts any slip in flight but keeps the current alignment.
        if (!i_signal_ok) begin
            w_state_d    = ARMED;
            w_settle_d   = '0;
            w_sh_valid_d = 1'b0;
        end else begin
            unique case (r_state)
                ARMED: begin
                    if (i_slip) begin
                        w_slip_take    = 1'b1;
                        w_bit_offset_d = w_offset_last ? '0 : r_bit_offset + OFFSET_W'(1);
                        w_settle_d     = SETTLE_W'(SETTLE_BLK);
                        w_state_d      = SETTLE;
                    end else if (i_in_enable) begin
                        w_sh_valid_d    = sh_is_valid(i_sync_hdr);
                        w_test_sh_set_d = 1'b1;
                    end
                end
                SETTLE: begin
                    if (i_in_enable) begin
                        if (r_settle <= SETTLE_W'(1)) begin
                            w_settle_d        = '0;
                            w_state_d         = DONE;
                            w_slip_done_set_d = 1'b1;
                        end else begin
                            w_settle_d = r_settle - SETTLE_W'(1);
                        end
                    end
                end
                DONE: begin
                    w_state_d = WAIT_LOW;
                end
                WAIT_LOW: begin
                    // Keep testing headers here so the lock FSM can restart its count early.
                    if (i_in_enable) begin
                        w_sh_valid_d    = sh_is_valid(i_sync_hdr);
                        w_test_sh_set_d = 1'b1;
                    end
                    if (!i_slip) begin
                        w_state_d = ARMED;
                    end
                end
                default: begin
                    w_state_d = ARMED;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state         <= ARMED;
            r_settle        <= '0;
            r_bit_offset    <= '0;
            r_sh_valid      <= 1'b0;
            r_test_sh_set   <= 1'b0;
            r_slip_done_set <= 1'b0;
        end else begin
            r_state         <= w_state_d;
            r_settle        <= w_settle_d;
            r_bit_offset    <= w_bit_offset_d;
            r_sh_valid      <= w_sh_valid_d;
            r_test_sh_set   <= w_test_sh_set_d;
            r_slip_done_set <= w_slip_done_set_d;
        end
    end

    assign o_sh_valid      = r_sh_valid;
    assign o_test_sh_set   = r_test_sh_set;
    assign o_slip_done_set = r_slip_done_set;
    assign o_bit_offset    = r_bit_offset;

`ifdef XFIPCS_SLIP_STATS_EN
    logic w_wrap;

    assign w_wrap = w_slip_take && w_offset_last && !i_block_lock;

    xfipcs_sat_cnt #(
        .W (CNT_W)
    ) u_slip_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_reset_n),
        .i_clr   (1'b0),
        .i_inc   (w_slip_take),
        .o_cnt   (o_slip_cnt)
    );

    xfipcs_sat_cnt #(
        .W (CNT_W)
    ) u_hunt_wrap_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_reset_n),
        .i_clr   (1'b0),
        .i_inc   (w_wrap),
        .o_cnt   (o_hunt_wrap_cnt)
    );
`else
    logic w_unused;

    assign w_unused        = i_block_lock ^ w_slip_take;
    assign o_slip_cnt      = '0;
    assign o_hunt_wrap_cnt = '0;
`endif

endmodule

// File: tb/tb_xfipcs_slip_ctrl.sv
// Randomised scoreboard bench for xfipcs_slip_ctrl; expectations follow the statistics build macro.
module tb_xfipcs_slip_ctrl;

    localparam int unsigned NUM_POS    = 66;
    localparam int unsigned OFFSET_W   = 7;
    localparam int unsigned SETTLE_BLK = 4;
    localparam int unsigned CNT_W      = 8;
    localparam int          CNT_MAX    = (1 << CNT_W) - 1;
`ifdef XFIPCS_SLIP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                clk;
    logic                rst_n;
    logic                in_en;
    logic [1:0]          hdr;
    logic                sok;
    logic                slip;
    logic                blk_lock;
    logic                o_sh_valid;
    logic                o_test_sh_set;
    logic                o_slip_done_set;
    logic [OFFSET_W-1:0] o_bit_offset;
    logic [CNT_W-1:0]    o_slip_cnt;
    logic [CNT_W-1:0]    o_hunt_wrap_cnt;

    xfipcs_slip_ctrl #(
        .NUM_POS    (NUM_POS),
        .OFFSET_W   (OFFSET_W),
        .SETTLE_BLK (SETTLE_BLK),
        .CNT_W      (CNT_W)
    ) dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_in_enable     (in_en),
        .i_sync_hdr      (hdr),
        .i_signal_ok     (sok),
        .i_slip          (slip),
        .i_block_lock    (blk_lock),
        .o_sh_valid      (o_sh_valid),
        .o_test_sh_set   (o_test_sh_set),
        .o_slip_done_set (o_slip_done_set),
        .o_bit_offset    (o_bit_offset),
        .o_slip_cnt      (o_slip_cnt),
        .o_hunt_wrap_cnt (o_hunt_wrap_cnt)
    );

    typedef struct {
        int cyc;
        int shv;
        int off;
    } test_exp_t;

    typedef struct {
        int cyc;
        int off;
        int sc;
        int wc;
    } done_exp_t;

    test_exp_t tq[$];
    done_exp_t dq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference state: alignment and statistics as seen by an observer of completed slips.
    int m_off = 0;
    int m_sc  = 0;
    int m_wc  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    function automatic int stat(input int v);
        return STATS ? v : 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A block issued in ARMED or WAIT_LOW is answered one cycle later.
    task automatic send_block(input logic [1:0] h);
        test_exp_t e;
        in_en = 1'b1;
        hdr   = h;
        e.cyc = cyc + 1;
        e.shv = (h inside {2'b01, 2'b10}) ? 1 : 0;
        e.off = m_off;
        tq.push_back(e);
        step();
        in_en = 1'b0;
    endtask

    task automatic idle(input int n);
        in_en = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_slip(input bit with_blk, input bit abort);
        done_exp_t d;
        int        n;
        bit        wrapped;
        slip    = 1'b1;
        in_en   = with_blk;
        hdr     = 2'($urandom);
        wrapped = (m_off == NUM_POS - 1);
        m_off   = wrapped ? 0 : m_off + 1;
        m_sc    = sat_inc(m_sc);
        if (wrapped && !blk_lock) m_wc = sat_inc(m_wc);
        step();
        n = 0;
        while (n < SETTLE_BLK) begin
            if (abort && n == 2) begin
                sok   = 1'b0;
                slip  = 1'b0;
                in_en = 1'($urandom_range(0, 1));
                step();
                chk("abort_offset", o_bit_offset, m_off);
                chk("abort_sh_valid", o_sh_valid, 0);
                sok   = 1'b1;
                in_en = 1'b0;
                idle(3);
                return;
            end
            in_en = 1'($urandom_range(0, 1));
            hdr   = 2'($urandom);
            if (in_en) begin
                n++;
                if (n == SETTLE_BLK) begin
                    d.cyc = cyc + 1;
                    d.off = m_off;
                    d.sc  = stat(m_sc);
                    d.wc  = stat(m_wc);
                    dq.push_back(d);
                end
            end
            step();
        end
        in_en = 1'b0;
        step();
        repeat ($urandom_range(0, 2)) send_block(2'($urandom));
        slip = 1'b0;
        if ($urandom_range(0, 1) == 1) send_block(2'($urandom));
        else step();
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (tq.size() > 0 && tq[0].cyc < cyc) begin
                chk("missed_test_sh_set", 0, 1);
                void'(tq.pop_front());
            end
            if (dq.size() > 0 && dq[0].cyc < cyc) begin
                chk("missed_slip_done_set", 0, 1);
                void'(dq.pop_front());
            end
            if (o_test_sh_set) begin
                if (tq.size() == 0) begin
                    chk("unexpected_test_sh_set", 1, 0);
                end else begin
                    test_exp_t e;
                    e = tq.pop_front();
                    chk("test_sh_set_cycle", cyc, e.cyc);
                    chk("sh_valid", o_sh_valid, e.shv);
                    chk("test_bit_offset", o_bit_offset, e.off);
                end
            end
            if (o_slip_done_set) begin
                if (dq.size() == 0) begin
                    chk("unexpected_slip_done_set", 1, 0);
                end else begin
                    done_exp_t d;
                    d = dq.pop_front();
                    chk("slip_done_cycle", cyc, d.cyc);
                    chk("done_bit_offset", o_bit_offset, d.off);
                    chk("done_slip_cnt", o_slip_cnt, d.sc);
                    chk("done_hunt_wrap_cnt", o_hunt_wrap_cnt, d.wc);
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_en    = 1'b0;
        hdr      = 2'b00;
        sok      = 1'b1;
        slip     = 1'b0;
        blk_lock = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_bit_offset", o_bit_offset, 0);
        chk("reset_sh_valid", o_sh_valid, 0);
        chk("reset_test_sh_set", o_test_sh_set, 0);
        chk("reset_slip_done_set", o_slip_done_set, 0);
        chk("reset_slip_cnt", o_slip_cnt, 0);
        chk("reset_hunt_wrap_cnt", o_hunt_wrap_cnt, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) send_block(2'b01);
        chk("offset_after_blocks", o_bit_offset, 0);
        send_block(2'b11);

        do_slip(1'b0, 1'b0);
        idle(2);
        chk("first_slip_offset", o_bit_offset, 1);
        chk("first_slip_cnt", o_slip_cnt, stat(1));

        do_slip(1'b1, 1'b0);
        idle(2);
        chk("slip_wins_offset", o_bit_offset, 2);

        blk_lock = 1'b0;
        for (int i = 0; i < 64; i++) begin
            do_slip(1'($urandom_range(0, 1)), 1'b0);
            repeat ($urandom_range(0, 2)) send_block(2'($urandom));
        end
        idle(1);
        chk("wrap_offset", o_bit_offset, 0);
        chk("wrap_hunt_cnt", o_hunt_wrap_cnt, stat(1));
        chk("wrap_slip_cnt", o_slip_cnt, stat(66));

        for (int i = 0; i < 4; i++) do_slip(1'b0, 1'b0);
        do_slip(1'b0, 1'b1);
        chk("drop_offset_kept", o_bit_offset, 5);
        send_block(2'b10);
        do_slip(1'b0, 1'b0);
        idle(1);
        chk("after_drop_offset", o_bit_offset, 6);

        for (int i = 0; i < 240; i++) begin
            blk_lock = 1'($urandom_range(0, 1));
            do_slip(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
            repeat ($urandom_range(0, 2)) send_block(2'($urandom));
        end
        idle(2);
        chk("sat_slip_cnt", o_slip_cnt, stat(CNT_MAX));
        chk("final_hunt_wrap_cnt", o_hunt_wrap_cnt, stat(m_wc));
        chk("final_offset", o_bit_offset, m_off);

        for (int i = 0; i < 20 && (tq.size() > 0 || dq.size() > 0); i++) step();
        chk("drain_test_queue", tq.size(), 0);
        chk("drain_done_queue", dq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
